// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a small serial SRAM (READ 0x03 / WRITE 0x02).
// Runs on the system clock and oversamples the SPI pins through 2-flop synchronizers.
module spi_sram_responder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_in,
  input  logic cs_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic miso_oe_out,
  output logic busy_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ADDR_BITS + 1);
  // only the low AW address bits survive (mod DEPTH); 8 bits are needed for the command
  localparam int SW = (AW > 8) ? AW : 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_IGN  = 3'd5;

  logic [1:0]    sclk_s, cs_s, mosi_s;
  logic          sclk_q;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [SW-2:0] sh;
  logic          op_rd;
  logic [AW-1:0] addr;
  logic [7:0]    dsh;
  logic [7:0]    mem [DEPTH];

  logic          cs_act, rise, fall, wr_en;
  logic [SW-1:0] sh_next;
  logic [7:0]    byte_next;
  logic [AW-1:0] addr_inc;

  assign cs_act    = ~cs_s[1];
  assign rise      = cs_act & sclk_s[1] & ~sclk_q;
  assign fall      = cs_act & ~sclk_s[1] & sclk_q;
  assign sh_next   = {sh, mosi_s[1]};
  assign byte_next = {dsh[6:0], mosi_s[1]};
  assign addr_inc  = addr + 1'b1;
  assign wr_en     = cs_act && (state == S_WR) && rise && (cnt == CW'(7));

  assign busy_out  = (state != S_IDLE);
  assign miso_out  = miso_oe_out & dsh[7];

  // pin synchronizers; CS resets deasserted so a CS held low at release reads as a fresh fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= 2'b11;
      mosi_s <= '0;
      sclk_q <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk_in};
      cs_s   <= {cs_s[0], cs_in};
      mosi_s <= {mosi_s[0], mosi_in};
      sclk_q <= sclk_s[1];
    end
  end

  // protocol FSM: command, address, then read or write data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sh          <= '0;
      op_rd       <= 1'b0;
      addr        <= '0;
      dsh         <= '0;
      miso_oe_out <= 1'b0;
    end else if (!cs_act) begin
      state       <= S_IDLE;
      cnt         <= '0;
      miso_oe_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_CMD;
          cnt   <= '0;
        end
        S_CMD: if (rise) begin
          sh <= sh_next[SW-2:0];
          if (cnt == CW'(7)) begin
            cnt <= '0;
            if (sh_next[7:0] == 8'h03) begin
              op_rd <= 1'b1;
              state <= S_ADDR;
            end else if (sh_next[7:0] == 8'h02) begin
              op_rd <= 1'b0;
              state <= S_ADDR;
            end else begin
              state <= S_IGN;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ADDR: if (rise) begin
          sh <= sh_next[SW-2:0];
          if (cnt == CW'(ADDR_BITS - 1)) begin
            cnt  <= '0;
            addr <= sh_next[AW-1:0];
            if (op_rd) begin
              // load the first byte right away so the MSB is on MISO long before the next rise
              dsh         <= mem[sh_next[AW-1:0]];
              miso_oe_out <= 1'b1;
              state       <= S_RD;
            end else begin
              state <= S_WR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD: begin
          // count data rises; the fall trailing the last address bit (cnt==0) must not shift
          if (rise) begin
            cnt <= cnt + 1'b1;
          end else if (fall) begin
            if (cnt == CW'(8)) begin
              cnt  <= '0;
              addr <= addr_inc;
              dsh  <= mem[addr_inc];
            end else if (cnt != '0) begin
              dsh <= {dsh[6:0], 1'b0};
            end
          end
        end
        S_WR: if (rise) begin
          dsh <= byte_next;
          if (cnt == CW'(7)) begin
            cnt  <= '0;
            addr <= addr_inc;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IGN: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  // byte store; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= byte_next;
  end
endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
Synthesizable SPI mode-0 responder that emulates a small serial SRAM/PSRAM device. It answers the CPU's SPI master with READ (0x03) and WRITE (0x02) commands followed by a 24-bit address, backed by an internal byte array. It runs on the system clock and oversamples the SPI pins. It is used on-chip and in benches as the responder end of the CPU's memory SPI bus, in place of an external PSRAM.

Parameters:
DEPTH, 256, bytes of internal storage; power of two, 16..1024.
ADDR_BITS, 24, address bits received after the command byte; multiple of 8.

Ports:
clk  input  1  system clock; SCLK must be at most clk/8
rst_n  input  1  asynchronous active-low reset
sclk_in  input  1  SPI clock from master; idle low (mode 0)
cs_in  input  1  chip select, active low
mosi_in  input  1  master-to-responder serial data, MSB first
miso_out  output  1  responder-to-master serial data, MSB first
miso_oe_out  output  1  high while the responder drives MISO (READ data phase only)
busy_out  output  1  high while a transaction is in progress (CS low as seen after sync)

Behaviour:
- Synchronization: sclk_in, cs_in and mosi_in pass through 2-flop synchronizers on clk. Rise and fall edges of SCLK are detected from the synchronized value. The synchronized mosi is sampled on the detected SCLK rise.
- Reset: asynchronous. All outputs are 0, FSM is IDLE, counters are 0. Memory contents are not reset (undefined until written).
- CS edges: a CS rise in any state returns the FSM to IDLE within 1 clk. miso_oe_out and busy_out drop on the same clk. SCLK edges seen while CS is high are ignored.
- FSM states:
  - IDLE: go to CMD when synced CS goes low. Clear the bit counter.
  - CMD: shift 8 bits. After the 8th rise:
    - 0x03 -> ADDR, op = read
    - 0x02 -> ADDR, op = write
    - any other value -> IGNORE
  - ADDR: shift ADDR_BITS bits. After the last rise, latch addr = received value mod DEPTH (upper bits dropped). Then go to RD_DATA or WR_DATA.
  - RD_DATA:
    - On entry, load the shift register with mem[addr] and drive miso_oe_out = 1.
    - miso_out presents the MSB before the first data SCLK rise.
    - Each SCLK fall shifts the next bit out.
    - After 8 falls, addr increments and the shift register reloads from mem[addr], so bursts are unbounded.
  - WR_DATA:
    - Shift 8 bits on SCLK rises. On the 8th rise, write mem[addr] = byte; the write is visible 1 clk later. Then addr increments.
    - A partial byte (fewer than 8 bits) at CS rise is discarded.
  - IGNORE: discard all bits until CS rises. miso_oe_out stays 0.
- Address wrap: increment past DEPTH-1 wraps to 0 in both read and write.
- Read timing: the first data bit must be valid by the first SCLK rise after the last address bit. This requires the mem read plus shift-register load within 3 clk of the last address rise, which the clk/8 SCLK limit guarantees.
- Write-then-read across transactions: data written in one transaction is returned by any later read. The 1-clk commit completes before CS can be observed high.
- miso_out is 0 whenever miso_oe_out is 0.
- Reset mid-transaction: all state clears immediately. The next transaction must start with a fresh CS fall; a CS already low at reset release is treated as a new CS fall.

Test Plan:
- Write burst: CS low, 0x02, addr 0x000010, data 0xA5 0x5A 0x3C 0xC3, CS high -> mem[0x10..0x13] hold those bytes; miso_oe_out stays 0 throughout.
- Read burst: CS low, 0x03, addr 0x000010, 32 SCLKs -> MISO returns 0xA5 0x5A 0x3C 0xC3 MSB first; miso_oe_out is high exactly over the data phase.
- Wrap: write 0x11 at DEPTH-1 and 0x22 continuing the burst; read from DEPTH-1 for 2 bytes -> 0x11 then 0x22, with mem[0] = 0x22. Address 0x0100FF with DEPTH=256 aliases to 0xFF.
- Unknown command: CS low, 0x9F, 32 SCLKs -> miso_oe_out = 0 and miso_out = 0 throughout; memory unchanged; the next valid READ works.
- Abort: WRITE to 0x20 with CS raised after 5 data bits -> mem[0x20] unchanged; busy_out falls within 3 clk of cs_in rising.
- Reset mid-read: assert rst_n low during the RD_DATA phase -> miso_oe_out and busy_out are 0 while reset is asserted; after release, a new transaction reading 0x10 returns 0xA5.
